// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Divide-by-zero quotient: all ones in the low `width` bits.
    function automatic logic [63:0] div0_quotient(input int width);
        return {64{1'b1}} >> (64 - width);
    endfunction

    // Most-negative two's-complement value; also the signed-overflow quotient.
    function automatic logic [63:0] most_negative(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] overflow_remainder(input int width);
        return 64'd0 & div0_quotient(width);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between the issue stage and the divider.
interface seq_divider_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output in_valid, dividend, divisor, is_signed, flush, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, flush, out_ready,
        output in_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division iteration on magnitudes, MSB first.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The extra bit holds the shifted-out remainder MSB, so trial's top bit is its sign.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor_mag};
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave div_bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(div0_quotient(WIDTH));
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_negative(WIDTH));
    localparam logic [WIDTH-1:0] OVF_REM  = WIDTH'(overflow_remainder(WIDTH));

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dmag;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             neg_q, neg_r;

    logic             accept;
    logic             dvd_neg, dvs_neg;
    logic             div_zero, overflow;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    assign accept   = div_bus.in_valid && (state == IDLE) && !div_bus.flush;
    assign dvd_neg  = div_bus.is_signed && div_bus.dividend[WIDTH-1];
    assign dvs_neg  = div_bus.is_signed && div_bus.divisor[WIDTH-1];
    assign dvd_mag  = dvd_neg ? -div_bus.dividend : div_bus.dividend;
    assign dvs_mag  = dvs_neg ? -div_bus.divisor : div_bus.divisor;
    assign div_zero = (div_bus.divisor == '0);
    assign overflow = div_bus.is_signed && (div_bus.dividend == MOST_NEG)
                      && (div_bus.divisor == ALL_ONES);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem        (rem),
        .quo        (quo),
        .divisor_mag(dmag),
        .rem_next   (rem_step),
        .quo_next   (quo_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        div_bus.in_ready  = 1'b0;
        div_bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                div_bus.in_ready = 1'b1;
                if (accept) state_next = (div_zero || overflow) ? DONE : CALC;
            end
            CALC: if (cnt == CNT_W'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: begin
                div_bus.out_valid = 1'b1;
                if (div_bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides both accept and consume.
        if (div_bus.flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dmag  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    neg_q <= dvd_neg ^ dvs_neg;
                    neg_r <= dvd_neg;
                    dmag  <= dvs_mag;
                    if (div_zero) begin
                        quo <= ALL_ONES;
                        rem <= div_bus.dividend;
                    end else if (overflow) begin
                        quo <= div_bus.dividend;
                        rem <= OVF_REM;
                    end else begin
                        quo <= dvd_mag;
                        rem <= '0;
                        cnt <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    if (neg_q) quo <= -quo;
                    if (neg_r) rem <= -rem;
                end
                default: ;
            endcase
        end
    end

    assign div_bus.quotient  = quo;
    assign div_bus.remainder = rem;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed RISC-V cases at WIDTH=32, random ops, exhaustive WIDTH=4.
module tb_seq_divider;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seq_divider_if #(.WIDTH(32)) d32 ();
    seq_divider_if #(.WIDTH(4))  d4 ();

    seq_divider #(.WIDTH(32)) u_div32 (.clk(clk), .rst(rst), .div_bus(d32.slave));
    seq_divider #(.WIDTH(4))  u_div4  (.clk(clk), .rst(rst), .div_bus(d4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the RISC-V special-case rules.
    function automatic void model(input int w, input bit sg, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        sa = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        if (b == 0) begin
            q = mask;
            r = a;
        end else if (sg && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
            q = a;
            r = 0;
        end else if (sg) begin
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic bit is_special(input int w, input bit sg, input logic [63:0] a,
                                      input logic [63:0] b);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (b == 0) || (sg && a == (64'd1 << (w - 1)) && b == mask);
    endfunction

    task automatic do32(input logic [31:0] a, input logic [31:0] b, input bit sg,
                        input int stall, input string tag);
        logic [63:0] eq, er;
        int          lat;
        model(32, sg, 64'(a), 64'(b), eq, er);
        d32.dividend  = a;
        d32.divisor   = b;
        d32.is_signed = sg;
        d32.in_valid  = 1'b1;
        tick();
        d32.in_valid = 1'b0;
        lat = 1;
        while (!d32.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, 64'(d32.out_valid), 64'd1);
        check({tag, "_lat"}, 64'(lat), is_special(32, sg, 64'(a), 64'(b)) ? 64'd1 : 64'd34);
        check({tag, "_q"}, 64'(d32.quotient), eq);
        check({tag, "_r"}, 64'(d32.remainder), er);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold_in_ready"}, 64'(d32.in_ready), 64'd0);
            check({tag, "_hold_q"}, 64'(d32.quotient), eq);
            check({tag, "_hold_r"}, 64'(d32.remainder), er);
        end
        d32.out_ready = 1'b1;
        tick();
        d32.out_ready = 1'b0;
        check({tag, "_in_ready_back"}, 64'(d32.in_ready), 64'd1);
    endtask

    task automatic do4(input logic [3:0] a, input logic [3:0] b, input bit sg);
        logic [63:0] eq, er;
        int          lat;
        model(4, sg, 64'(a), 64'(b), eq, er);
        d4.dividend  = a;
        d4.divisor   = b;
        d4.is_signed = sg;
        d4.in_valid  = 1'b1;
        tick();
        d4.in_valid = 1'b0;
        lat = 1;
        while (!d4.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        repeat ($urandom_range(0, 3)) tick();
        check($sformatf("w4_%0d_%0d_%0d_q", sg, a, b), 64'(d4.quotient), eq);
        check($sformatf("w4_%0d_%0d_%0d_r", sg, a, b), 64'(d4.remainder), er);
        d4.out_ready = 1'b1;
        tick();
        d4.out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        bit          rs;

        rst = 1'b1;
        d32.in_valid = 0; d32.dividend = 0; d32.divisor = 0; d32.is_signed = 0;
        d32.flush = 0;    d32.out_ready = 0;
        d4.in_valid = 0;  d4.dividend = 0;  d4.divisor = 0;  d4.is_signed = 0;
        d4.flush = 0;     d4.out_ready = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", 64'(d32.in_ready), 64'd1);
        check("rst_out_valid", 64'(d32.out_valid), 64'd0);
        check("rst_q", 64'(d32.quotient), 64'd0);
        check("rst_r", 64'(d32.remainder), 64'd0);

        do32(32'd100, 32'd7, 1'b0, 0, "u100_7");
        check("u100_7_q_abs", 64'(d32.quotient), 64'd14);
        check("u100_7_r_abs", 64'(d32.remainder), 64'd2);
        do32(-32'sd7, 32'd2, 1'b1, 0, "sm7_2");
        do32(32'd7, -32'sd2, 1'b1, 0, "s7_m2");
        do32(32'd5, 32'd0, 1'b0, 0, "u5_0");
        do32(32'd5, 32'd0, 1'b1, 0, "s5_0");
        do32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "ovf");
        check("ovf_q_abs", 64'(d32.quotient), 64'h8000_0000);
        do32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_big");
        do32(32'd1000, 32'd33, 1'b0, 10, "stall");

        // Accept presented together with flush must be dropped.
        d32.dividend = 32'd5; d32.divisor = 32'd0; d32.is_signed = 1'b0;
        d32.in_valid = 1'b1; d32.flush = 1'b1;
        tick();
        d32.in_valid = 1'b0; d32.flush = 1'b0;
        check("flush_accept_in_ready", 64'(d32.in_ready), 64'd1);
        check("flush_accept_out_valid", 64'(d32.out_valid), 64'd0);

        // Flush in CALC cycle 5.
        d32.dividend = 32'd100; d32.divisor = 32'd7; d32.in_valid = 1'b1;
        tick();
        d32.in_valid = 1'b0;
        repeat (4) tick();
        check("flush_busy", 64'(d32.in_ready), 64'd0);
        d32.flush = 1'b1;
        tick();
        d32.flush = 1'b0;
        check("flush_idle", 64'(d32.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (d32.out_valid) seen++;
            tick();
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Reset in the middle of CALC.
        d32.dividend = 32'd100; d32.divisor = 32'd7; d32.in_valid = 1'b1;
        tick();
        d32.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 64'(d32.in_ready), 64'd1);
        check("midrst_out_valid", 64'(d32.out_valid), 64'd0);
        check("midrst_q", 64'(d32.quotient), 64'd0);
        check("midrst_r", 64'(d32.remainder), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (d32.out_valid) seen++;
            tick();
        end
        check("midrst_no_valid", 64'(seen), 64'd0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom >> $urandom_range(0, 28);
            rs = 1'($urandom_range(0, 1));
            do32(ra, rb, rs, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do4(4'(a), 4'(b), 1'(s));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
